hsid_x_obi_rd_master: RTL and testbench

- OBI read initiator: the requesting end of the bus carried by obi_req_t/obi_resp_t.
- Fetches word_count consecutive 32-bit words starting at base_addr.
- Buffers the read data in an internal FIFO and presents it on a valid/ready stream.
- Feeds pixel/vector data from OBI memory into the HSID-X datapath; replaces testbench-driven OBI stimulus.

---
 rtl/hsid_x_obi_inf_pkg.sv | 23 ++
 rtl/hsid_x_obi_rd_fifo.sv | 50 +++++
 rtl/hsid_x_obi_rd_master.sv | 111 +++++++++++
 tb/tb_hsid_x_obi_rd_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI bus types plus the constants and state encoding shared by the read master.
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  localparam logic [3:0]  OBI_BE_ALL     = 4'hF;
  localparam int unsigned OBI_WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rd_master_state_e;

endpackage

// File: rtl/hsid_x_obi_rd_fifo.sv
// Synchronous FIFO; push and pop may coincide at any occupancy, no fall-through.
module hsid_x_obi_rd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/hsid_x_obi_rd_master.sv
// OBI read initiator: fetches word_count words from base_addr and streams them out in order.
module hsid_x_obi_rd_master
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output obi_req_t         obi_req,
  input  obi_resp_t        obi_rsp
);

  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  rd_master_state_e state, state_nxt;

  logic [CNT_W-1:0] count, issued, received, outstanding;
  logic [31:0]      addr;
  logic             req, req_hold, accept, rsp_take, pop;
  logic             fifo_empty, fifo_full, credit_ok;
  logic [FC_W-1:0]  fifo_count;
  logic [CNT_W:0]   inflight;

  assign outstanding = issued - received;
  assign inflight    = {1'b0, outstanding} + (CNT_W+1)'(fifo_count);
  // Every granted request reserves a FIFO slot, so rvalid can never overflow.
  assign credit_ok   = !fifo_full && (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign accept      = req && obi_rsp.gnt;
  assign rsp_take    = obi_rsp.rvalid && (outstanding != '0);
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (word_count != '0) ? RUN : DONE;
      RUN:  if (received == count && fifo_empty && !pop) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A raised but ungranted request stays up regardless of credits.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    req  = (state == RUN) && (req_hold || ((issued < count) && credit_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      issued   <= '0;
      received <= '0;
      addr     <= '0;
      req_hold <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        count    <= word_count;
        issued   <= '0;
        received <= '0;
        addr     <= {base_addr[31:2], 2'b00};
      end
      if (accept) begin
        issued <= issued + 1'b1;
        addr   <= addr + 32'(OBI_WORD_BYTES);
      end
      if (rsp_take) received <= received + 1'b1;
      req_hold <= req && !obi_rsp.gnt;
    end
  end

  always_comb begin
    obi_req       = '0;
    obi_req.req   = req;
    obi_req.we    = 1'b0;
    obi_req.be    = OBI_BE_ALL;
    obi_req.addr  = addr;
    obi_req.wdata = '0;
  end

  hsid_x_obi_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_take),
    .wdata (obi_rsp.rdata),
    .pop   (pop),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_hsid_x_obi_rd_master.sv
// Randomized bench: memory model with variable gnt/rvalid timing, scoreboard of expected addresses/data.
module tb_hsid_x_obi_rd_master;
  import hsid_x_obi_inf_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, out_valid, out_ready;
  logic [31:0]      out_data;
  obi_req_t         obi_req;
  obi_resp_t        obi_rsp;

  hsid_x_obi_rd_master #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .obi_req(obi_req), .obi_rsp(obi_rsp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; int due; } rsp_t;

  int          checks = 0, errors = 0;
  int          cyc = 0, grants = 0, pops = 0;
  int          gmode = 0, rmode = 0, ymode = 0;
  int          need = 0, waited = 0;
  int          first_gnt = -1, first_ov = -1;
  bit          hold_mem = 0, late_rv = 0, in_req = 0, prev_pend = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  rsp_t        rq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h1234_5678);
  endfunction

  // One cycle of the memory/consumer model, called at the negedge.
  task automatic act();
    int pops_b = pops;
    int lat;
    case (ymode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      if (exp_data.size() == 0) chk("spurious_out", out_valid, 0);
      else if (out_ready) begin
        chk("out_data", out_data, exp_data.pop_front());
        pops++;
      end
    end
    if (obi_req.req) chk("const_fields", {obi_req.we, obi_req.be, obi_req.wdata}, {1'b0, 4'hF, 32'h0});
    if (prev_pend) begin
      chk("req_hold", obi_req.req, 1);
      chk("addr_hold", obi_req.addr, prev_addr);
    end
    obi_rsp.rvalid = 1'b0;
    obi_rsp.rdata  = $urandom;
    if (late_rv) begin
      obi_rsp.rvalid = 1'b1;
      obi_rsp.rdata  = 32'h0BAD_0BAD;
    end else if (!hold_mem && rq.size() != 0 && rq[0].due <= cyc) begin
      obi_rsp.rvalid = 1'b1;
      obi_rsp.rdata  = rq[0].d;
      void'(rq.pop_front());
    end
    obi_rsp.gnt = 1'b0;
    if (obi_req.req && !hold_mem) begin
      if (!in_req) begin
        in_req = 1;
        waited = 0;
        need = (gmode == 2) ? ((grants % 3 == 2) ? 2 : 0) :
               (gmode == 1) ? int'($urandom_range(0, 2)) : 0;
      end
      if (waited >= need) begin
        obi_rsp.gnt = 1'b1;
        in_req = 0;
        if (first_gnt < 0) first_gnt = cyc;
        if (grants < exp_addr.size()) chk("addr", obi_req.addr, exp_addr[grants]);
        else chk("extra_req", obi_req.req, 0);
        chk("credit", 64'((grants + 1 - pops_b) <= FIFO_DEPTH), 1);
        lat = (rmode == 0) ? 1 : (rmode == 1) ? int'($urandom_range(1, 3)) : 3;
        rq.push_back('{d: mem_fn(obi_req.addr), due: cyc + lat});
        grants++;
      end else waited++;
    end
    prev_pend = obi_req.req && !obi_rsp.gnt;
    prev_addr = obi_req.addr;
    cyc++;
  endtask

  task automatic step();
    act();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setup(input logic [31:0] base, input int cnt, input int gm, input int rm, input int ym);
    logic [31:0] a = {base[31:2], 2'b00};
    gmode = gm; rmode = rm; ymode = ym;
    grants = 0; pops = 0; first_gnt = -1; first_ov = -1;
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem_fn(a));
      a = a + 32'd4;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input int cnt,
                          input int gm, input int rm, input int ym, input bit mid_start);
    bit seen = 0;
    setup(base, cnt, gm, rm, ym);
    base_addr = base; word_count = CNT_W'(cnt); start = 1'b1;
    step();
    start = 1'b0; base_addr = $urandom; word_count = CNT_W'($urandom);
    if (ym == 2) begin
      for (int k = 0; k < 20; k++) step();
      chk({tag, "_bp_grants"}, 64'(grants), 64'(FIFO_DEPTH));
      chk({tag, "_bp_req_low"}, obi_req.req, 0);
      chk({tag, "_bp_no_pop"}, 64'(pops), 0);
      ymode = 0;
    end
    for (int k = 0; k < 2000 && !seen; k++) begin
      if (mid_start && k == 3) begin
        start = 1'b1; base_addr = 32'h0000_BAD0; word_count = CNT_W'(5);
      end else start = 1'b0;
      step();
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_grants"}, 64'(grants), 64'(cnt));
    chk({tag, "_pops"}, 64'(pops), 64'(cnt));
    chk({tag, "_busy_at_done"}, busy, 1);
    if (gm == 0 && rm == 0 && cnt == 1) chk({tag, "_latency"}, 64'(first_ov - first_gnt), 2);
    step();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
    obi_rsp = '0;
    hold_mem = 1;
    @(negedge clk);
    step(); step();
    chk("rst_req", obi_req.req, 0);
    chk("rst_addr", obi_req.addr, 0);
    chk("rst_const", {obi_req.we, obi_req.be, obi_req.wdata}, {1'b0, 4'hF, 32'h0});
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0; hold_mem = 0;
    step();

    run_xfer("single", 32'h100, 1, 0, 0, 0, 0);
    run_xfer("stall", 32'h1000, 8, 2, 0, 0, 0);
    run_xfer("backpressure", 32'h3000, 10, 0, 0, 2, 0);
    run_xfer("wrap", 32'hFFFF_FFFA, 3, 0, 1, 1, 0);

    // Zero-length transfer: done next cycle, no bus activity.
    setup(32'h500, 0, 0, 0, 0);
    base_addr = 32'h500; word_count = '0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zc_done", done, 1);
    chk("zc_busy", busy, 1);
    step();
    chk("zc_done_once", done, 0);
    chk("zc_busy_fall", busy, 0);
    chk("zc_no_req", 64'(grants), 0);

    for (int i = 0; i < 6; i++)
      run_xfer("rand", $urandom, int'($urandom_range(1, 12)), 1, 1, 1, (i == 0));

    // Reset with two reads in flight.
    setup(32'h2000, 8, 0, 2, 2);
    base_addr = 32'h2000; word_count = CNT_W'(8); start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 50 && grants < 2; k++) step();
    chk("mid_rst_grants", 64'(grants), 2);
    hold_mem = 1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", obi_req.req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    rq.delete(); exp_addr.delete(); exp_data.delete();
    prev_pend = 0; in_req = 0; hold_mem = 0;
    late_rv = 1;
    step(); step();
    late_rv = 0;
    step();
    chk("late_rv_out_valid", out_valid, 0);
    chk("late_rv_busy", busy, 0);
    run_xfer("after_rst", 32'h4004, 5, 1, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
